// File: rtl/sevenseg_capture.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment display.
// Waits for each anode slot to settle, decodes it and publishes whole frames atomically.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT_BITS  = 20,
  parameter bit          SYNC_EN       = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_out,
  output logic       frame_valid,
  output logic       frame_strobe,
  output logic       code_err
);

  localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned NUM_DIG  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] WD_MAX = {TIMEOUT_BITS{1'b1}};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } scan_t;

  localparam scan_t IDLE_SCAN = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};

  scan_t raw_c;
  scan_t sync1_q, sync1_d;
  scan_t sync2_q, sync2_d;
  scan_t in_q, in_d;
  scan_t prev_q, prev_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic [NUM_DIG-1:0]      mask_q, mask_d;
  logic [NUM_DIG-1:0][DIGIT_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIG-1:0]      shadow_dp_q, shadow_dp_d;
  logic [NUM_DIG-1:0][DIGIT_W-1:0] digit_q, digit_d;
  logic [NUM_DIG-1:0]      dp_out_q, dp_out_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_strobe_q, frame_strobe_d;
  logic                    code_err_q, code_err_d;

  logic               same_c;
  logic               settle_c;
  logic               slot_valid_c;
  logic [1:0]         slot_idx_c;
  logic               sample_c;
  logic               publish_c;
  logic               timeout_c;
  logic [DIGIT_W-1:0] dec_code_c;
  logic               dec_err_c;

  assign raw_c = {an, g, f, e, d, c, b, a, dp};

  // Optional two-flop synchroniser ahead of the input register.
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
    in_d    = SYNC_EN ? sync2_q : raw_c;
    prev_d  = in_q;
  end

  // Settle detection: sample once, on the cycle the run length hits STABLE_CYCLES.
  always_comb begin
    same_c   = (in_q == prev_q);
    settle_c = same_c && (cnt_q == CNT_SETTLE);
    cnt_d    = '0;
    if (same_c) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Only a single active-low anode counts as a digit slot.
  always_comb begin
    slot_valid_c = 1'b1;
    slot_idx_c   = 2'd0;
    case (in_q.an)
      4'b1110: slot_idx_c = 2'd0;
      4'b1101: slot_idx_c = 2'd1;
      4'b1011: slot_idx_c = 2'd2;
      4'b0111: slot_idx_c = 2'd3;
      default: slot_valid_c = 1'b0;
    endcase
  end

  assign sample_c = settle_c && slot_valid_c;

  // Active-low {g,f,e,d,c,b,a} back to a digit code; dash maps to 4'hA.
  always_comb begin
    dec_code_c = 4'hF;
    dec_err_c  = 1'b0;
    case (in_q.seg)
      7'b1000000: dec_code_c = 4'h0;
      7'b1111001: dec_code_c = 4'h1;
      7'b0100100: dec_code_c = 4'h2;
      7'b0110000: dec_code_c = 4'h3;
      7'b0011001: dec_code_c = 4'h4;
      7'b0010010: dec_code_c = 4'h5;
      7'b0000010: dec_code_c = 4'h6;
      7'b1111000: dec_code_c = 4'h7;
      7'b0000000: dec_code_c = 4'h8;
      7'b0010000: dec_code_c = 4'h9;
      7'b0111111: dec_code_c = 4'hA;
      default: begin
        dec_code_c = 4'hF;
        dec_err_c  = 1'b1;
      end
    endcase
  end

  // Watchdog, shadow capture and frame publish.
  always_comb begin
    wd_d           = wd_q;
    mask_d         = mask_q;
    shadow_d       = shadow_q;
    shadow_dp_d    = shadow_dp_q;
    digit_d        = digit_q;
    dp_out_d       = dp_out_q;
    frame_valid_d  = frame_valid_q;
    frame_strobe_d = 1'b0;
    code_err_d     = 1'b0;

    if (sample_c) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + TIMEOUT_BITS'(1);
    end

    publish_c = (mask_q == 4'b1111);
    timeout_c = (wd_d == WD_MAX);

    if (publish_c || timeout_c) begin
      mask_d = '0;
    end

    if (publish_c) begin
      digit_d        = shadow_q;
      dp_out_d       = shadow_dp_q;
      frame_strobe_d = 1'b1;
      frame_valid_d  = 1'b1;
    end else if (timeout_c) begin
      frame_valid_d = 1'b0;
    end

    // A sample in the publish cycle lands in the next frame.
    if (sample_c) begin
      shadow_d[slot_idx_c]    = dec_code_c;
      shadow_dp_d[slot_idx_c] = in_q.dp;
      mask_d                  = mask_d | ~in_q.an;
      code_err_d              = dec_err_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q        <= IDLE_SCAN;
      sync2_q        <= IDLE_SCAN;
      in_q           <= IDLE_SCAN;
      prev_q         <= IDLE_SCAN;
      cnt_q          <= '0;
      wd_q           <= '0;
      mask_q         <= '0;
      shadow_q       <= '0;
      shadow_dp_q    <= '1;
      digit_q        <= '0;
      dp_out_q       <= '1;
      frame_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
      code_err_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      in_q           <= in_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      wd_q           <= wd_d;
      mask_q         <= mask_d;
      shadow_q       <= shadow_d;
      shadow_dp_q    <= shadow_dp_d;
      digit_q        <= digit_d;
      dp_out_q       <= dp_out_d;
      frame_valid_q  <= frame_valid_d;
      frame_strobe_q <= frame_strobe_d;
      code_err_q     <= code_err_d;
    end
  end

  assign digit0       = digit_q[0];
  assign digit1       = digit_q[1];
  assign digit2       = digit_q[2];
  assign digit3       = digit_q[3];
  assign dp_out       = dp_out_q;
  assign frame_valid  = frame_valid_q;
  assign frame_strobe = frame_strobe_q;
  assign code_err     = code_err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: scan frames, bad codes, short holds, timeout, mid-frame reset.
module tb_sevenseg_capture;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BAD  = 7'b1010101;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic       clock;
  logic       reset;
  logic       a_i, b_i, c_i, d_i, e_i, f_i, g_i, dp_i;
  logic [3:0] an_i;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_out;
  logic       frame_valid, frame_strobe, code_err;

  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int last_strobe_cyc = -1;
  int last_err_cyc = -1;
  int fall_cyc = -1;
  int last_drive_cyc = 0;
  bit fv_prev = 1'b0;
  int checks = 0;
  int errors = 0;

  sevenseg_capture #(
    .STABLE_CYCLES(4),
    .TIMEOUT_BITS (6),
    .SYNC_EN      (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .a           (a_i),
    .b           (b_i),
    .c           (c_i),
    .d           (d_i),
    .e           (e_i),
    .f           (f_i),
    .g           (g_i),
    .dp          (dp_i),
    .an          (an_i),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .frame_strobe(frame_strobe),
    .code_err    (code_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Event recorder: pulse counts and the cycle each event was seen.
  always @(negedge clock) begin
    if (frame_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
    if (code_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (fv_prev && !frame_valid) fall_cyc = cyc;
    fv_prev = frame_valid;
  end

  task automatic show(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dp_v, input int n);
    @(negedge clock);
    an_i = an_v;
    {g_i, f_i, e_i, d_i, c_i, b_i, a_i} = seg_v;
    dp_i = dp_v;
    last_drive_cyc = cyc;
    repeat (n) @(posedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int c3;
    int s_base;
    int e_base;

    reset = 1'b1;
    an_i  = 4'b1111;
    {g_i, f_i, e_i, d_i, c_i, b_i, a_i} = OFF;
    dp_i  = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    show(4'b1111, OFF, 1'b1, 2);
    @(negedge clock);
    chk("rst_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0000);
    chk("rst_dp_out", {28'h0, dp_out}, 32'hF);
    chk("rst_valid", {31'h0, frame_valid}, 32'h0);
    chk("rst_strobe", {31'h0, frame_strobe}, 32'h0);
    chk("rst_code_err", {31'h0, code_err}, 32'h0);

    // Short holds and idle anode patterns never sample
    show(4'b1110, S0, 1'b1, 3);
    show(4'b1101, S1, 1'b1, 3);
    show(4'b1011, S2, 1'b1, 3);
    show(4'b0111, S3, 1'b1, 3);
    show(4'b1110, S4, 1'b1, 3);
    show(4'b1111, S5, 1'b1, 10);
    show(4'b1100, S8, 1'b1, 10);
    show(4'b1111, OFF, 1'b1, 3);
    @(negedge clock);
    chk("short_strobes", strobe_cnt, 0);
    chk("short_errs", err_cnt, 0);
    chk("short_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0000);
    chk("short_dp_out", {28'h0, dp_out}, 32'hF);
    chk("short_valid", {31'h0, frame_valid}, 32'h0);

    // Basic frame 0,1,2,3 with dp lit on slot 1
    show(4'b1110, S0, 1'b1, 8);
    show(4'b1101, S1, 1'b0, 8);
    show(4'b1011, S2, 1'b1, 8);
    show(4'b0111, S3, 1'b1, 8);
    c3 = last_drive_cyc;
    show(4'b1111, OFF, 1'b1, 4);
    @(negedge clock);
    chk("f1_strobes", strobe_cnt, 1);
    chk("f1_strobe_cyc", last_strobe_cyc, c3 + 9);
    chk("f1_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h3210);
    chk("f1_dp_out", {28'h0, dp_out}, 32'hD);
    chk("f1_valid", {31'h0, frame_valid}, 32'h1);
    chk("f1_errs", err_cnt, 0);

    // Dash and an undecodable pattern
    show(4'b1110, S4, 1'b1, 8);
    show(4'b1101, S9, 1'b1, 8);
    show(4'b1011, DASH, 1'b1, 8);
    show(4'b0111, BAD, 1'b1, 8);
    c3 = last_drive_cyc;
    show(4'b1111, OFF, 1'b1, 4);
    @(negedge clock);
    chk("f2_strobes", strobe_cnt, 2);
    chk("f2_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'hFA94);
    chk("f2_errs", err_cnt, 1);
    chk("f2_err_cyc", last_err_cyc, c3 + 8);
    chk("f2_dp_out", {28'h0, dp_out}, 32'hF);
    chk("f2_valid", {31'h0, frame_valid}, 32'h1);

    // Slot 0 revisited before completion, then watchdog timeout
    show(4'b1110, S5, 1'b1, 8);
    show(4'b1101, S1, 1'b1, 8);
    show(4'b1110, S7, 1'b1, 8);
    show(4'b1011, S8, 1'b1, 8);
    show(4'b0111, S3, 1'b1, 8);
    c3 = last_drive_cyc;
    show(4'b1111, OFF, 1'b1, 70);
    @(negedge clock);
    chk("f3_strobes", strobe_cnt, 3);
    chk("f3_strobe_cyc", last_strobe_cyc, c3 + 9);
    chk("to_fall_cyc", fall_cyc, c3 + 8 + 63);
    chk("to_valid", {31'h0, frame_valid}, 32'h0);
    chk("to_digits_held", {16'h0, digit3, digit2, digit1, digit0}, 32'h3817);

    // Fresh scan after timeout re-raises frame_valid
    show(4'b1110, S9, 1'b1, 8);
    show(4'b1101, S8, 1'b1, 8);
    show(4'b1011, S7, 1'b1, 8);
    show(4'b0111, S6, 1'b1, 8);
    show(4'b1111, OFF, 1'b1, 4);
    @(negedge clock);
    chk("f4_strobes", strobe_cnt, 4);
    chk("f4_valid", {31'h0, frame_valid}, 32'h1);
    chk("f4_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h6789);

    // Reset after slots 0 and 1, then scan 2,3,0,1
    s_base = strobe_cnt;
    e_base = err_cnt;
    show(4'b1110, S1, 1'b1, 8);
    show(4'b1101, S2, 1'b1, 8);
    @(negedge clock);
    reset = 1'b1;
    an_i  = 4'b1111;
    {g_i, f_i, e_i, d_i, c_i, b_i, a_i} = OFF;
    dp_i  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mr_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0000);
    chk("mr_valid", {31'h0, frame_valid}, 32'h0);
    show(4'b1011, S4, 1'b1, 8);
    show(4'b0111, S5, 1'b1, 8);
    show(4'b1110, S6, 1'b1, 8);
    show(4'b1111, OFF, 1'b1, 3);
    @(negedge clock);
    chk("mr_no_strobe", strobe_cnt, s_base);
    show(4'b1101, S7, 1'b1, 8);
    c3 = last_drive_cyc;
    show(4'b1111, OFF, 1'b1, 4);
    @(negedge clock);
    chk("mr_strobes", strobe_cnt, s_base + 1);
    chk("mr_strobe_cyc", last_strobe_cyc, c3 + 9);
    chk("mr_digits_new", {16'h0, digit3, digit2, digit1, digit0}, 32'h5476);
    chk("mr_valid_new", {31'h0, frame_valid}, 32'h1);
    chk("mr_errs", err_cnt, e_base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive-side counterpart of the team's multiplexed 4-digit seven-segment driver.
- Watches the active-low anode enables and active-low segment lines, and waits for each digit slot to settle.
- Decodes each settled segment pattern back to a 4-bit code and publishes all four digits atomically once per complete scan frame.
- Used for loopback self-test of the display path and as a bench/board monitor of whatever the display driver is showing.

Parameters:
- STABLE_CYCLES, 16: consecutive unchanged cycles of {an, segments} required before a digit slot is sampled (>=2).
- TIMEOUT_BITS, 20: width of the watchdog counter; 2^TIMEOUT_BITS-1 idle cycles without a capture drops frame_valid.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a, b, c, d, e, f, g  in  1 each  segment lines, active-low
- dp  in  1  decimal point, active-low; ignored for decoding, latched per digit
- an  in  4  digit enables, active-low one-hot; an[0] = digit 0
- digit0, digit1, digit2, digit3  out  4 each  decoded codes of the last complete frame
- dp_out  out  4  latched dp per digit of the last complete frame (1 = off)
- frame_valid  out  1  high once a full frame is published; low after reset or timeout
- frame_strobe  out  1  one-cycle pulse when the digit outputs update
- code_err  out  1  one-cycle pulse when a sampled pattern has no valid decode

Behaviour:
- Reset (async, active-high): digits = 0, dp_out = 4'b1111, frame_valid = 0, frame_strobe = 0, code_err = 0; internal seen mask, stability counter and watchdog = 0.
- Input registering: sample {an, g..a, dp} into a register each clock. All logic uses the registered copy; add a 2-flop synchroniser when the inputs are off-chip.
- Stability counter:
  - Increments while the registered {an, seg, dp} equals its previous-cycle value; saturates at STABLE_CYCLES.
  - Clears to 0 on any change.
  - A slot is sampled in the single cycle the counter transitions to STABLE_CYCLES. No re-sampling until the inputs change.
- Anode qualification: sample only if an is exactly one of 1110, 1101, 1011, 0111. Any other value (1111, or multiple lows) is idle; the counter still runs but no sample is taken.
- Decode of active-low {g,f,e,d,c,b,a}:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 0111111 (dash) = 4'hA.
  - Any other pattern = 4'hF and code_err pulses in the same cycle as the sample.
- Capture: a sample writes the shadow digit and dp for the enabled slot and sets that bit in the seen mask. A re-sample of an already-seen slot overwrites the shadow and leaves the mask unchanged.
- Frame publish:
  - In the cycle after the mask becomes 4'b1111: copy shadows to digit0..3 and dp_out, assert frame_strobe for exactly 1 cycle, set frame_valid, clear the mask.
  - A sample that lands in the publish cycle is kept and counts toward the next frame.
  - Latency from the completing sample to the output update is 1 clock.
- Watchdog:
  - Clears on every sample; otherwise increments and saturates at all-ones.
  - At saturation: frame_valid = 0 and the mask clears. Digit outputs hold their last values.
  - The next complete frame re-asserts frame_valid.
- Outputs are registered and update only on frame_strobe. No combinational path from inputs to outputs.
- Reset asserted mid-frame discards partial shadows and the mask; after release, a full 4-slot frame is required before publishing.

Test Plan:
- STABLE_CYCLES=4. Drive an=1110/seg=1000000, then 1101/1111001, 1011/0100100, 0111/0110000, each held 8 cycles -> one frame_strobe 1 cycle after the 4th slot's sample; digit0..3 = 0,1,2,3; frame_valid = 1; code_err never pulses.
- Same scan, but slot 2 shows 0111111 and slot 3 shows 1010101 -> digit2 = 4'hA, digit3 = 4'hF, code_err pulses exactly once.
- Slot held only 3 cycles (< STABLE_CYCLES) between changes, plus an=1111 and an=1100 intervals -> no samples, no frame_strobe, outputs stay at reset values.
- Scan order 0,1,0,2,3 with slot 0 showing 5 and then 7 -> a single frame_strobe; digit0 = 7.
- TIMEOUT_BITS=6. After a valid frame, hold an=1111 for 70 cycles -> frame_valid falls at cycle 63 after the last sample; digits retain their values. A new full scan re-raises frame_valid.
- Assert reset for 1 cycle after slots 0 and 1 are sampled, then scan slots 2,3,0,1 -> no strobe until slot 1 is sampled again, then one strobe with the new values.
